// File: rtl/audioplay_display_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | audioplay_display_pkg: shared types, chipselect indices, seg LUT      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package audioplay_display_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR_S0 = 3'd1,
    WR_S1 = 3'd2,
    WR_M0 = 3'd3,
    WR_M1 = 3'd4
  } state_t;

  localparam int CS_SEC0 = 0;
  localparam int CS_SEC1 = 1;
  localparam int CS_MIN0 = 2;
  localparam int CS_MIN1 = 3;

  // Active-high gfedcba codes; element [d] is the code for digit d.
  localparam logic [9:0][6:0] SEG_LUT = {
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
    7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // MM:SS BCD increment, 99:59 wraps to 00:00.
  function automatic logic [15:0] bcd_time_inc(input logic [15:0] t);
    logic [15:0] n;
    n = t;
    if (t[3:0] != 4'd9) begin
      n[3:0] = t[3:0] + 4'd1;
    end else begin
      n[3:0] = 4'd0;
      if (t[7:4] != 4'd5) begin
        n[7:4] = t[7:4] + 4'd1;
      end else begin
        n[7:4] = 4'd0;
        if (t[11:8] != 4'd9) begin
          n[11:8] = t[11:8] + 4'd1;
        end else begin
          n[11:8]  = 4'd0;
          n[15:12] = (t[15:12] == 4'd9) ? 4'd0 : t[15:12] + 4'd1;
        end
      end
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/audioplay_seg7_enc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | audioplay_seg7_enc: BCD digit to 7-segment code, optional inversion   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module audioplay_seg7_enc
  import audioplay_display_pkg::*;
#(
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  logic [6:0] raw;

  always_comb begin
    raw = 7'h00;
    if (bcd <= 4'd9) raw = SEG_LUT[bcd];
    seg = (SEG_ACTIVE_LOW != 0) ? ~raw : raw;
  end

endmodule
`default_nettype wire

// File: rtl/audioplay_time_display_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | audioplay_time_display_ctrl: MM:SS counter refreshing 4 display PIOs  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module audioplay_time_display_ctrl
  import audioplay_display_pkg::*;
#(
  parameter int CLK_HZ         = 50_000_000,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        clear,
  output logic [1:0]  address,
  output logic        write_n,
  output logic [31:0] writedata,
  output logic [3:0]  chipselect,
  output logic        busy,
  output logic [15:0] time_bcd
);

  localparam int            PW        = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

  logic [PW-1:0] prescaler;
  logic          tick;
  logic          pending;
  logic          seq_start;
  state_t        state, next_state;
  logic [15:0]   snap, src;
  logic [3:0]    digit;
  logic [3:0]    cs_next;
  logic [6:0]    seg, seg_q;

  assign tick      = run && (prescaler == PRESC_MAX);
  assign seq_start = (state == IDLE) && pending;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler <= '0;
      time_bcd  <= '0;
    end else if (clear) begin
      prescaler <= '0;
      time_bcd  <= '0;
    end else if (run) begin
      prescaler <= tick ? '0 : prescaler + 1'b1;
      if (tick) time_bcd <= bcd_time_inc(time_bcd);
    end
  end

  // A new request arriving on the same edge a sequence starts must survive.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= 1'b1;
      snap    <= '0;
      state   <= IDLE;
    end else begin
      if (clear || tick)  pending <= 1'b1;
      else if (seq_start) pending <= 1'b0;
      if (seq_start) snap <= time_bcd;
      state <= next_state;
    end
  end

  // The first write launches on the snapshot edge, so it takes the live value.
  always_comb begin
    next_state = state;
    cs_next    = 4'b0000;
    digit      = 4'd0;
    src        = (state == IDLE) ? time_bcd : snap;
    unique case (state)
      IDLE:    if (pending) next_state = WR_S0;
      WR_S0:   next_state = WR_S1;
      WR_S1:   next_state = WR_M0;
      WR_M0:   next_state = WR_M1;
      WR_M1:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
    case (next_state)
      WR_S0:   begin cs_next[CS_SEC0] = 1'b1; digit = src[3:0];   end
      WR_S1:   begin cs_next[CS_SEC1] = 1'b1; digit = src[7:4];   end
      WR_M0:   begin cs_next[CS_MIN0] = 1'b1; digit = src[11:8];  end
      WR_M1:   begin cs_next[CS_MIN1] = 1'b1; digit = src[15:12]; end
      default: digit = 4'd0;
    endcase
  end

  audioplay_seg7_enc #(
    .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
  ) u_enc (
    .bcd(digit),
    .seg(seg)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_n    <= 1'b1;
      chipselect <= 4'b0000;
      seg_q      <= 7'h00;
    end else begin
      write_n    <= (next_state == IDLE);
      chipselect <= cs_next;
      if (next_state != IDLE) seg_q <= seg;
    end
  end

  assign address   = 2'b00;
  assign writedata = {25'b0, seg_q};
  assign busy      = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_audioplay_time_display_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_audioplay_time_display_ctrl: directed bench, CLK_HZ=4, active-low  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_audioplay_time_display_ctrl;

  logic        clk = 1'b0;
  logic        reset, run, clear;
  logic [1:0]  address;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  chipselect;
  logic        busy;
  logic [15:0] time_bcd;

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0]  rec_cs   [0:15];
  logic [31:0] rec_wd   [0:15];
  logic        rec_wn   [0:15];
  logic        rec_busy [0:15];
  logic [15:0] rec_time [0:15];

  audioplay_time_display_ctrl #(
    .CLK_HZ(4),
    .SEG_ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .run(run),
    .clear(clear),
    .address(address),
    .write_n(write_n),
    .writedata(writedata),
    .chipselect(chipselect),
    .busy(busy),
    .time_bcd(time_bcd)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Sample n cycles at negedges; pulse clear for one cycle after sample clear_at.
  task automatic record(input int n, input int clear_at);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rec_cs[i]   = chipselect;
      rec_wd[i]   = writedata;
      rec_wn[i]   = write_n;
      rec_busy[i] = busy;
      rec_time[i] = time_bcd;
      clear       = (i == clear_at);
    end
    clear = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] exp_wd [0:3];
    exp_wd = '{32'h40, 32'h40, 32'h40, 32'h40};
    reset = 1'b1; run = 1'b0; clear = 1'b0;
    step(3);
    n_cmp++;
    if (write_n !== 1'b1 || chipselect !== 4'b0 || address !== 2'b0 ||
        writedata !== 32'h0 || busy !== 1'b0 || time_bcd !== 16'h0) begin
      n_bad++;
      $display("FAIL reset_values: wn=%b cs=%h addr=%h wd=%h busy=%b t=%h, want 1/0/0/0/0/0",
               write_n, chipselect, address, writedata, busy, time_bcd);
    end
    reset = 1'b0;
    record(6, -1);
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (rec_cs[k] !== 4'(1 << k) || rec_wn[k] !== 1'b0 || rec_wd[k] !== exp_wd[k] || rec_busy[k] !== 1'b1) begin
        n_bad++;
        $display("FAIL reset_seq[%0d]: cs=%h wn=%b wd=%h busy=%b, want cs=%h wn=0 wd=%h busy=1",
                 k, rec_cs[k], rec_wn[k], rec_wd[k], rec_busy[k], 4'(1 << k), exp_wd[k]);
      end
    end
    n_cmp++;
    if (rec_cs[4] !== 4'b0 || rec_wn[4] !== 1'b1 || rec_busy[4] !== 1'b0 || rec_wd[4] !== 32'h40 ||
        rec_cs[5] !== 4'b0 || rec_busy[5] !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle: cs=%h wn=%b busy=%b wd=%h, want cs=0 wn=1 busy=0 wd=00000040",
               rec_cs[4], rec_wn[4], rec_busy[4], rec_wd[4]);
    end
  endtask

  task automatic test_single_tick;
    logic [31:0] exp_wd [0:3];
    exp_wd = '{32'h79, 32'h40, 32'h40, 32'h40};
    run = 1'b1;
    step(4);
    run = 1'b0;
    n_cmp++;
    if (time_bcd !== 16'h0001) begin
      n_bad++;
      $display("FAIL tick_time: got %h want 0001", time_bcd);
    end
    record(6, -1);
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (rec_cs[k] !== 4'(1 << k) || rec_wn[k] !== 1'b0 || rec_wd[k] !== exp_wd[k]) begin
        n_bad++;
        $display("FAIL tick_seq[%0d]: cs=%h wn=%b wd=%h, want cs=%h wn=0 wd=%h",
                 k, rec_cs[k], rec_wn[k], rec_wd[k], 4'(1 << k), exp_wd[k]);
      end
    end
    n_cmp++;
    if (rec_wn[4] !== 1'b1 || rec_cs[4] !== 4'b0 || rec_busy[4] !== 1'b0) begin
      n_bad++;
      $display("FAIL tick_idle: wn=%b cs=%h busy=%b, want 1/0/0", rec_wn[4], rec_cs[4], rec_busy[4]);
    end
  endtask

  task automatic test_minute_carry;
    logic [31:0] exp_wd [0:3];
    exp_wd = '{32'h40, 32'h40, 32'h40, 32'h79};
    run = 1'b1;
    step(598 * 4);
    run = 1'b0;
    step(12);
    n_cmp++;
    if (time_bcd !== 16'h0959 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL preload_0959: time=%h busy=%b, want 0959 busy=0", time_bcd, busy);
    end
    run = 1'b1;
    step(4);
    run = 1'b0;
    n_cmp++;
    if (time_bcd !== 16'h1000) begin
      n_bad++;
      $display("FAIL carry_time: got %h want 1000", time_bcd);
    end
    record(6, -1);
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (rec_cs[k] !== 4'(1 << k) || rec_wn[k] !== 1'b0 || rec_wd[k] !== exp_wd[k]) begin
        n_bad++;
        $display("FAIL carry_seq[%0d]: cs=%h wn=%b wd=%h, want cs=%h wn=0 wd=%h",
                 k, rec_cs[k], rec_wn[k], rec_wd[k], 4'(1 << k), exp_wd[k]);
      end
    end
  endtask

  task automatic test_wrap;
    run = 1'b1;
    step(5399 * 4);
    run = 1'b0;
    step(12);
    n_cmp++;
    if (time_bcd !== 16'h9959) begin
      n_bad++;
      $display("FAIL preload_9959: got %h want 9959", time_bcd);
    end
    run = 1'b1;
    step(4);
    run = 1'b0;
    n_cmp++;
    if (time_bcd !== 16'h0000) begin
      n_bad++;
      $display("FAIL wrap_time: got %h want 0000", time_bcd);
    end
    record(6, -1);
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (rec_cs[k] !== 4'(1 << k) || rec_wn[k] !== 1'b0 || rec_wd[k] !== 32'h40) begin
        n_bad++;
        $display("FAIL wrap_seq[%0d]: cs=%h wn=%b wd=%h, want cs=%h wn=0 wd=00000040",
                 k, rec_cs[k], rec_wn[k], rec_wd[k], 4'(1 << k));
      end
    end
  endtask

  task automatic test_clear;
    // clear on the same edge as a tick: clear must win
    run = 1'b1;
    step(3);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    run = 1'b0;
    n_cmp++;
    if (time_bcd !== 16'h0000) begin
      n_bad++;
      $display("FAIL clear_vs_tick: got %h want 0000", time_bcd);
    end
    record(6, -1);
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (rec_cs[k] !== 4'(1 << k) || rec_wn[k] !== 1'b0 || rec_wd[k] !== 32'h40) begin
        n_bad++;
        $display("FAIL clear_seq[%0d]: cs=%h wn=%b wd=%h, want cs=%h wn=0 wd=00000040",
                 k, rec_cs[k], rec_wn[k], rec_wd[k], 4'(1 << k));
      end
    end
    // clear mid-count must restart the prescaler
    run = 1'b1;
    step(2);
    run = 1'b0;
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    run = 1'b1;
    step(3);
    n_cmp++;
    if (time_bcd !== 16'h0000) begin
      n_bad++;
      $display("FAIL presc_clear_early: got %h want 0000", time_bcd);
    end
    step(1);
    run = 1'b0;
    n_cmp++;
    if (time_bcd !== 16'h0001) begin
      n_bad++;
      $display("FAIL presc_clear_tick: got %h want 0001", time_bcd);
    end
    step(12);
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_wd [0:9];
    logic [3:0]  exp_cs [0:9];
    logic        exp_wn [0:9];
    exp_wd = '{32'h24, 32'h40, 32'h40, 32'h40, 32'h40, 32'h40, 32'h40, 32'h40, 32'h40, 32'h40};
    exp_cs = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0};
    exp_wn = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    run = 1'b1;
    step(4);
    run = 1'b0;
    n_cmp++;
    if (time_bcd !== 16'h0002) begin
      n_bad++;
      $display("FAIL b2b_time: got %h want 0002", time_bcd);
    end
    record(10, 0);
    n_cmp++;
    if (rec_time[1] !== 16'h0000) begin
      n_bad++;
      $display("FAIL b2b_clear_time: got %h want 0000", rec_time[1]);
    end
    for (int k = 0; k < 10; k++) begin
      n_cmp++;
      if (rec_cs[k] !== exp_cs[k] || rec_wn[k] !== exp_wn[k] || rec_wd[k] !== exp_wd[k]) begin
        n_bad++;
        $display("FAIL b2b_cycle[%0d]: cs=%h wn=%b wd=%h, want cs=%h wn=%b wd=%h",
                 k, rec_cs[k], rec_wn[k], rec_wd[k], exp_cs[k], exp_wn[k], exp_wd[k]);
      end
    end
  endtask

  task automatic test_reset_mid_sequence;
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    step(3);
    n_cmp++;
    if (chipselect !== 4'b0100 || write_n !== 1'b0) begin
      n_bad++;
      $display("FAIL pre_reset_wr_m0: cs=%h wn=%b, want cs=4 wn=0", chipselect, write_n);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (write_n !== 1'b1 || chipselect !== 4'b0 || busy !== 1'b0 || writedata !== 32'h0 || time_bcd !== 16'h0) begin
      n_bad++;
      $display("FAIL async_reset: wn=%b cs=%h busy=%b wd=%h t=%h, want 1/0/0/0/0",
               write_n, chipselect, busy, writedata, time_bcd);
    end
    step(2);
    reset = 1'b0;
    record(6, -1);
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (rec_cs[k] !== 4'(1 << k) || rec_wn[k] !== 1'b0 || rec_wd[k] !== 32'h40) begin
        n_bad++;
        $display("FAIL post_reset_seq[%0d]: cs=%h wn=%b wd=%h, want cs=%h wn=0 wd=00000040",
                 k, rec_cs[k], rec_wn[k], rec_wd[k], 4'(1 << k));
      end
    end
    n_cmp++;
    if (rec_wn[4] !== 1'b1 || rec_cs[4] !== 4'b0 || rec_busy[4] !== 1'b0) begin
      n_bad++;
      $display("FAIL post_reset_idle: wn=%b cs=%h busy=%b, want 1/0/0", rec_wn[4], rec_cs[4], rec_busy[4]);
    end
  endtask

  initial begin
    reset = 1'b1;
    run   = 1'b0;
    clear = 1'b0;
    test_reset();
    test_single_tick();
    test_minute_carry();
    test_wrap();
    test_clear();
    test_back_to_back();
    test_reset_mid_sequence();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
